// File: rtl/gpi_debounce.sv
// ============================================================================
// Module   : gpi_debounce
// Purpose  : Synchronises raw GPI pins, rejects bounce, emits rise/fall pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpi_debounce #(
    parameter int unsigned      Width          = 1,
    parameter int unsigned      DebounceCycles = 50000,
    parameter int unsigned      SyncStages     = 2,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int unsigned        c_cnt_w    = $clog2(DebounceCycles + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DebounceCycles - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    if (DebounceCycles < 1) begin : g_chk_debounce
        $error("gpi_debounce: DebounceCycles must be >= 1");
    end
    if (SyncStages < 2) begin : g_chk_sync
        $error("gpi_debounce: SyncStages must be >= 2");
    end
    if (Width < 1) begin : g_chk_width
        $error("gpi_debounce: Width must be >= 1");
    end

    for (genvar i = 0; i < Width; i++) begin : g_bit
        logic [SyncStages-1:0] r_sync;
        logic [c_cnt_w-1:0]    r_cnt;
        logic                  r_level;
        logic                  r_rise;
        logic                  r_fall;
        logic                  w_sync_out;
        logic                  w_differs;
        logic                  w_expired;

        assign w_sync_out = r_sync[SyncStages-1];
        assign w_differs  = (w_sync_out != r_level);
        assign w_expired  = (r_cnt == c_cnt_last);

        // Plain flop chain: no logic between stages to keep metastability settling clean.
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_sync <= {SyncStages{ResetValue[i]}};
            end else begin
                r_sync <= {r_sync[SyncStages-2:0], gp_raw_i[i]};
            end
        end

        // Any cycle of agreement restarts qualification, so bounce never accumulates.
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_cnt   <= '0;
                r_level <= ResetValue[i];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_expired) begin
                    r_cnt   <= '0;
                    r_level <= w_sync_out;
                    r_rise  <= w_sync_out;
                    r_fall  <= ~w_sync_out;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign gp_o[i]   = r_level;
        assign rise_o[i] = r_rise;
        assign fall_o[i] = r_fall;
    end

endmodule

`default_nettype wire

// File: tb/tb_gpi_debounce.sv
// ============================================================================
// Module   : tb_gpi_debounce
// Purpose  : Directed bench for gpi_debounce with a history-window reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpi_debounce;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] raw_a   = '0;
    logic [0:0] raw_b   = '0;
    logic [0:0] raw_c   = '0;
    logic [0:0] raw_d   = '0;

    logic [3:0] gp_a, rise_a, fall_a;
    logic [0:0] gp_b, rise_b, fall_b;
    logic [0:0] gp_c, rise_c, fall_c;
    logic [0:0] gp_d, rise_d, fall_d;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    gpi_debounce #(.Width(4), .DebounceCycles(4), .SyncStages(2), .ResetValue(4'b0000)) u_a (
        .clk_sys_i(clk_sys), .rst_sys_ni(rst_n), .gp_raw_i(raw_a),
        .gp_o(gp_a), .rise_o(rise_a), .fall_o(fall_a));
    gpi_debounce #(.Width(1), .DebounceCycles(8), .SyncStages(2), .ResetValue(1'b0)) u_b (
        .clk_sys_i(clk_sys), .rst_sys_ni(rst_n), .gp_raw_i(raw_b),
        .gp_o(gp_b), .rise_o(rise_b), .fall_o(fall_b));
    gpi_debounce #(.Width(1), .DebounceCycles(4), .SyncStages(2), .ResetValue(1'b1)) u_c (
        .clk_sys_i(clk_sys), .rst_sys_ni(rst_n), .gp_raw_i(raw_c),
        .gp_o(gp_c), .rise_o(rise_c), .fall_o(fall_c));
    gpi_debounce #(.Width(1), .DebounceCycles(1), .SyncStages(2), .ResetValue(1'b0)) u_d (
        .clk_sys_i(clk_sys), .rst_sys_ni(rst_n), .gp_raw_i(raw_d),
        .gp_o(gp_d), .rise_o(rise_d), .fall_o(fall_d));

    // Reference: output flips once the last D synchronised samples all disagree with it.
    int   c_dcyc  [4] = '{4, 8, 4, 1};
    int   c_width [4] = '{4, 1, 1, 1};
    logic c_rval  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic m_pipe  [4][4][2];
    logic m_hist  [4][4][8];
    int   m_valid [4][4];
    logic m_lvl   [4][4];
    logic m_rise  [4][4];
    logic m_fall  [4][4];

    function automatic logic raw_bit(int u, int b);
        case (u)
            0:       return raw_a[b];
            1:       return raw_b[0];
            2:       return raw_c[0];
            default: return raw_d[0];
        endcase
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 4; u++) begin
            for (int b = 0; b < 4; b++) begin
                m_pipe[u][b][0] = c_rval[u];
                m_pipe[u][b][1] = c_rval[u];
                for (int k = 0; k < 8; k++) m_hist[u][b][k] = 1'b0;
                m_valid[u][b] = 0;
                m_lvl[u][b]   = c_rval[u];
                m_rise[u][b]  = 1'b0;
                m_fall[u][b]  = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic s;
        bit   all_diff;
        for (int u = 0; u < 4; u++) begin
            for (int b = 0; b < c_width[u]; b++) begin
                s = m_pipe[u][b][1];
                for (int k = 7; k > 0; k--) m_hist[u][b][k] = m_hist[u][b][k-1];
                m_hist[u][b][0] = s;
                if (m_valid[u][b] < 8) m_valid[u][b]++;
                m_rise[u][b] = 1'b0;
                m_fall[u][b] = 1'b0;
                all_diff = (m_valid[u][b] >= c_dcyc[u]);
                for (int k = 0; k < c_dcyc[u]; k++)
                    if (m_hist[u][b][k] == m_lvl[u][b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[u][b]  = s;
                    m_rise[u][b] = s;
                    m_fall[u][b] = ~s;
                end
                m_pipe[u][b][1] = m_pipe[u][b][0];
                m_pipe[u][b][0] = raw_bit(u, b);
            end
        end
    endtask

    function automatic logic [3:0] exp_vec(int u, int kind);
        logic [3:0] v;
        v = '0;
        for (int b = 0; b < c_width[u]; b++)
            v[b] = (kind == 0) ? m_lvl[u][b] : (kind == 1) ? m_rise[u][b] : m_fall[u][b];
        return v;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_sys or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            chk("a_gp",   gp_a,             exp_vec(0, 0));
            chk("a_rise", rise_a,           exp_vec(0, 1));
            chk("a_fall", fall_a,           exp_vec(0, 2));
            chk("b_gp",   {3'b000, gp_b},   exp_vec(1, 0));
            chk("b_rise", {3'b000, rise_b}, exp_vec(1, 1));
            chk("b_fall", {3'b000, fall_b}, exp_vec(1, 2));
            chk("c_gp",   {3'b000, gp_c},   exp_vec(2, 0));
            chk("c_rise", {3'b000, rise_c}, exp_vec(2, 1));
            chk("c_fall", {3'b000, fall_c}, exp_vec(2, 2));
            chk("d_gp",   {3'b000, gp_d},   exp_vec(3, 0));
            chk("d_rise", {3'b000, rise_d}, exp_vec(3, 1));
            chk("d_fall", {3'b000, fall_d}, exp_vec(3, 2));
        end
    end

    // Unit-delay instance sees a pseudo-random pin for the whole run.
    initial begin
        forever begin
            @(posedge clk_sys);
            #2 raw_d = 1'($urandom_range(0, 1));
        end
    end

    task automatic ticks(int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    int bounce [6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        ticks(3);
        chk("lit_c_reset_gp", {3'b000, gp_c}, 4'b0001);
        chk("lit_a_reset_gp", gp_a, 4'b0000);
        rst_n = 1'b1;

        // ResetValue=1 with pin low: six cycles of 1, then a single fall.
        ticks(5);
        chk("lit_c_hold_gp", {3'b000, gp_c}, 4'b0001);
        ticks(1);
        chk("lit_c_fall_gp", {3'b000, gp_c}, 4'b0000);
        chk("lit_c_fall",    {3'b000, fall_c}, 4'b0001);
        ticks(1);
        chk("lit_c_fall_end", {3'b000, fall_c}, 4'b0000);

        // Clean step on bit 0.
        raw_a[0] = 1'b1;
        ticks(5);
        chk("lit_step_gp5", gp_a, 4'b0000);
        ticks(1);
        chk("lit_step_gp6", gp_a, 4'b0001);
        chk("lit_step_rise", rise_a, 4'b0001);
        ticks(1);
        chk("lit_step_rise_end", rise_a, 4'b0000);

        raw_a[0] = 1'b0;
        ticks(6);
        chk("lit_step_fall", fall_a, 4'b0001);
        ticks(2);

        // Three-cycle glitch is rejected.
        raw_a[0] = 1'b1;
        ticks(3);
        raw_a[0] = 1'b0;
        ticks(8);
        chk("lit_glitch_gp", gp_a, 4'b0000);

        // Exactly four cycles qualifies; falling edge follows six cycles after release.
        raw_a[0] = 1'b1;
        ticks(4);
        raw_a[0] = 1'b0;
        ticks(2);
        chk("lit_four_gp",   gp_a,   4'b0001);
        chk("lit_four_rise", rise_a, 4'b0001);
        ticks(3);
        chk("lit_four_hold", gp_a, 4'b0001);
        ticks(1);
        chk("lit_four_fall_gp", gp_a,   4'b0000);
        chk("lit_four_fall",    fall_a, 4'b0001);
        ticks(2);

        // Bounce on the D=8 instance.
        for (int k = 0; k < 6; k++) begin
            raw_b[0] = 1'(bounce[k]);
            ticks(1);
        end
        raw_b[0] = 1'b1;
        ticks(8);
        chk("lit_bounce_gp14", {3'b000, gp_b}, 4'b0000);
        ticks(1);
        chk("lit_bounce_gp15", {3'b000, gp_b},   4'b0001);
        chk("lit_bounce_rise", {3'b000, rise_b}, 4'b0001);
        ticks(2);

        // Multi-bit: bit0 at cycle 0, bit2 at cycle 2, bit1 two-cycle glitch.
        raw_a[0] = 1'b1;
        ticks(2);
        raw_a[2] = 1'b1;
        raw_a[1] = 1'b1;
        ticks(2);
        raw_a[1] = 1'b0;
        ticks(2);
        chk("lit_multi_gp6",   gp_a,   4'b0001);
        chk("lit_multi_rise6", rise_a, 4'b0001);
        ticks(2);
        chk("lit_multi_gp8",   gp_a,   4'b0101);
        chk("lit_multi_rise8", rise_a, 4'b0100);
        ticks(2);

        // Reset mid-count with pins held high, then full requalification.
        raw_a[3] = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_gp",   gp_a,   4'b0000);
        chk("lit_rst_rise", rise_a, 4'b0000);
        chk("lit_rst_fall", fall_a, 4'b0000);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk("lit_rel_gp5", gp_a, 4'b0000);
        ticks(1);
        chk("lit_rel_gp6",   gp_a,   4'b1101);
        chk("lit_rel_rise6", rise_a, 4'b1101);
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
